// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the register bridge and its helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps (size, low address bits) to byte-lane strobes and flags illegal size/alignment.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] wstrb_o,
    output logic       err_o
);

    always_comb begin
        wstrb_o = '0;
        err_o   = 1'b0;
        case (hsize_i)
            HSIZE_BYTE: wstrb_o = 4'b0001 << addr_i;
            HSIZE_HALF: begin
                wstrb_o = 4'b0011 << {addr_i[1], 1'b0};
                err_o   = addr_i[0];
            end
            HSIZE_WORD: begin
                wstrb_o = 4'b1111;
                err_o   = |addr_i;
            end
            default:    err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave front-end: address-phase capture, optional wait states, two-cycle
// ERROR response, one-cycle register write enables and muxed read data.
module ahb_reg_bridge
    import ahb_pkg::*;
#(
    parameter int NumRegs    = 8,
    parameter int AddrWidth  = 12,
    parameter int WaitStates = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    HSEL,
    input  logic [AddrWidth-1:0]    HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [NumRegs-1:0]      reg_wen,
    output logic [31:0]             reg_wdata,
    output logic [3:0]              reg_wstrb,
    input  logic [NumRegs*32-1:0]   reg_rdata
);

    localparam int IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    localparam logic [3:0] WaitLoad = 4'(WaitStates);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dp_q, dp_d;       // OKAY data phase in flight
    logic            write_q, write_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [3:0]      wstrb_q, wstrb_d;

    logic            accept;
    logic            bad_idx;
    logic            size_err;
    logic            commit;
    logic [3:0]      wstrb_bus;

    ahb_byte_strobe u_strobe (
        .hsize_i (HSIZE),
        .addr_i  (HADDR[1:0]),
        .wstrb_o (wstrb_bus),
        .err_o   (size_err)
    );

    assign accept  = HSEL && HREADY &&
                     ((htrans_t'(HTRANS) == HTRANS_NONSEQ) || (htrans_t'(HTRANS) == HTRANS_SEQ));
    assign bad_idx = 32'(HADDR[AddrWidth-1:2]) >= 32'(NumRegs);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_d    = dp_q;
        write_d = write_q;
        idx_d   = idx_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_IDLE;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE and ERR2 both end the current data phase on this edge
                state_d = S_IDLE;
                dp_d    = 1'b0;
                if (accept) begin
                    write_d = HWRITE;
                    idx_d   = HADDR[2 +: IdxW];
                    wstrb_d = wstrb_bus;
                    if (bad_idx || size_err) begin
                        state_d = S_ERR1;
                    end else begin
                        dp_d = 1'b1;
                        if (WaitStates > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = WaitLoad;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dp_q    <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign HRESP     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign commit    = (state_q == S_IDLE) && dp_q && write_q;

    assign reg_wen   = commit ? ({{(NumRegs-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign reg_wdata = HWDATA;
    assign reg_wstrb = commit ? wstrb_q : 4'b0000;
    assign HRDATA    = (dp_q && !write_q) ? reg_rdata[{idx_q, 5'b00000} +: 32] : 32'h0;

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Directed bench: zero-wait instance driven from a vector table, two-wait instance
// exercised with hand-written multi-cycle sequences.
module tb_ahb_reg_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel0 = 1'b0, sel2 = 1'b0;
    logic [11:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [31:0] hwdata = '0;

    logic        rdy0, resp0, rdy2, resp2;
    logic [31:0] rd0, rd2, wd0, wd2;
    logic [7:0]  wen0, wen2;
    logic [3:0]  ws0, ws2;
    logic [255:0] rdat0, rdat2;
    logic [31:0] bank0 [8];
    logic [31:0] bank2 [8];

    int ntest = 0;
    int nfail = 0;

    localparam logic [1:0] ID = 2'd0, BZ = 2'd1, NS = 2'd2, SQ = 2'd3;

    always #5 clk = ~clk;

    ahb_reg_bridge #(.NumRegs(8), .AddrWidth(12), .WaitStates(0)) dut0 (
        .clk(clk), .reset(reset), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0), .reg_wen(wen0),
        .reg_wdata(wd0), .reg_wstrb(ws0), .reg_rdata(rdat0)
    );

    ahb_reg_bridge #(.NumRegs(8), .AddrWidth(12), .WaitStates(2)) dut2 (
        .clk(clk), .reset(reset), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy2),
        .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rd2), .reg_wen(wen2),
        .reg_wdata(wd2), .reg_wstrb(ws2), .reg_rdata(rdat2)
    );

    // Behavioural register cells honouring byte strobes
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reset) bank0[i] <= 32'hA000_0000 | 32'(i);
            else if (wen0[i])
                for (int b = 0; b < 4; b++) if (ws0[b]) bank0[i][8*b +: 8] <= wd0[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (reset) bank2[i] <= (i == 1) ? 32'h1234_5678 : (32'hB000_0000 | 32'(i));
            else if (wen2[i])
                for (int b = 0; b < 4; b++) if (ws2[b]) bank2[i][8*b +: 8] <= wd2[8*b +: 8];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rdat0[32*i +: 32] = bank0[i];
            rdat2[32*i +: 32] = bank2[i];
        end
    end

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        resp;
        logic [7:0]  wen;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } vec_t;

    localparam int NV = 21;
    vec_t v [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic s0, input logic s2, input logic [1:0] t, input logic w,
                       input logic [2:0] sz, input logic [11:0] a);
        sel0 = s0; sel2 = s2; htrans = t; hwrite = w; hsize = sz; haddr = a;
    endtask

    initial begin
        // sel trans wr size addr   | data-phase wdata | rdy resp wen wstrb rdata
        v[0]  = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h0};
        v[1]  = '{1'b1, NS, 1'b1, 3'd2, 12'h00C, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h0};
        v[2]  = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'hDEADBEEF,  1'b1, 1'b0, 8'h08, 4'hF, 32'h0};
        v[3]  = '{1'b1, NS, 1'b1, 3'd0, 12'h006, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h0};
        v[4]  = '{1'b1, NS, 1'b1, 3'd1, 12'h00A, 32'h00AB_0000, 1'b1, 1'b0, 8'h02, 4'h4, 32'h0};
        v[5]  = '{1'b1, NS, 1'b0, 3'd2, 12'h00C, 32'hCDEF_0000, 1'b1, 1'b0, 8'h04, 4'hC, 32'h0};
        v[6]  = '{1'b1, NS, 1'b0, 3'd2, 12'h004, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'hDEADBEEF};
        v[7]  = '{1'b1, SQ, 1'b0, 3'd2, 12'h008, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'hA0AB_0001};
        v[8]  = '{1'b1, BZ, 1'b0, 3'd2, 12'h008, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'hCDEF_0002};
        v[9]  = '{1'b1, NS, 1'b1, 3'd2, 12'h008, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h0};
        v[10] = '{1'b1, NS, 1'b0, 3'd2, 12'h008, 32'h5555_AAAA, 1'b1, 1'b0, 8'h04, 4'hF, 32'h0};
        v[11] = '{1'b1, NS, 1'b0, 3'd2, 12'h020, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h5555_AAAA};
        v[12] = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'h0,         1'b0, 1'b1, 8'h00, 4'h0, 32'h0};
        v[13] = '{1'b1, NS, 1'b1, 3'd1, 12'h001, 32'h0,         1'b1, 1'b1, 8'h00, 4'h0, 32'h0};
        v[14] = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'hFFFF_FFFF, 1'b0, 1'b1, 8'h00, 4'h0, 32'h0};
        v[15] = '{1'b1, NS, 1'b0, 3'd2, 12'h000, 32'hFFFF_FFFF, 1'b1, 1'b1, 8'h00, 4'h0, 32'h0};
        v[16] = '{1'b1, NS, 1'b0, 3'd3, 12'h000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'hA000_0000};
        v[17] = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'h0,         1'b0, 1'b1, 8'h00, 4'h0, 32'h0};
        v[18] = '{1'b1, NS, 1'b1, 3'd2, 12'h01C, 32'h0,         1'b1, 1'b1, 8'h00, 4'h0, 32'h0};
        v[19] = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'h7777_0007, 1'b1, 1'b0, 8'h80, 4'hF, 32'h0};
        v[20] = '{1'b0, ID, 1'b0, 3'd2, 12'h000, 32'h0,         1'b1, 1'b0, 8'h00, 4'h0, 32'h0};

        // Power-on reset
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset dut0", 64'({rdy0, resp0, wen0, rd0}), 64'({1'b1, 1'b0, 8'h00, 32'h0}));
        chk("reset dut2", 64'({rdy2, resp2, wen2, rd2}), 64'({1'b1, 1'b0, 8'h00, 32'h0}));

        // Reset held 3 cycles while dut2 is in a wait-stated write
        @(negedge clk); bus(1'b0, 1'b1, NS, 1'b1, 3'd2, 12'h000);
        @(negedge clk); bus(1'b0, 1'b0, ID, 1'b0, 3'd2, 12'h000);
        hwdata = 32'hBAD0_BAD0;
        #1 chk("midwait rdy", 64'(rdy2), 64'(1'b0));
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk); #1 chk("reset wen", 64'(wen2), 64'(8'h00));
        end
        reset = 1'b0;
        @(negedge clk); #1
        chk("post-reset dut2", 64'({rdy2, resp2, wen2, rd2}), 64'({1'b1, 1'b0, 8'h00, 32'h0}));

        // Zero-wait table
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus(v[i].sel, 1'b0, v[i].trans, v[i].wr, v[i].size, v[i].addr);
            hwdata = v[i].wdata;
            #1;
            chk($sformatf("vec%0d", i), 64'({rdy0, resp0, wen0, ws0, rd0}),
                64'({v[i].rdy, v[i].resp, v[i].wen, v[i].wstrb, v[i].rdata}));
            if (v[i].wen != 8'h00) chk($sformatf("vec%0d wdata", i), 64'(wd0), 64'(v[i].wdata));
        end

        // Two wait states: read idx1
        @(negedge clk); bus(1'b0, 1'b1, NS, 1'b0, 3'd2, 12'h004); hwdata = 32'h0;
        @(negedge clk); bus(1'b0, 1'b0, ID, 1'b0, 3'd2, 12'h000);
        #1 chk("ws2 rd c1", 64'({rdy2, resp2}), 64'({1'b0, 1'b0}));
        @(negedge clk); #1 chk("ws2 rd c2", 64'({rdy2, resp2}), 64'({1'b0, 1'b0}));
        @(negedge clk); #1 chk("ws2 rd c3", 64'({rdy2, resp2, rd2}), 64'({1'b1, 1'b0, 32'h1234_5678}));

        // Two wait states: write idx4 commits only in the final cycle
        @(negedge clk); bus(1'b0, 1'b1, NS, 1'b1, 3'd2, 12'h010);
        @(negedge clk); bus(1'b0, 1'b0, ID, 1'b0, 3'd2, 12'h000); hwdata = 32'h4444_0004;
        #1 chk("ws2 wr c1", 64'({rdy2, wen2}), 64'({1'b0, 8'h00}));
        @(negedge clk); #1 chk("ws2 wr c2", 64'({rdy2, wen2}), 64'({1'b0, 8'h00}));
        @(negedge clk); #1 chk("ws2 wr c3", 64'({rdy2, wen2, ws2, wd2}),
                               64'({1'b1, 8'h10, 4'hF, 32'h4444_0004}));
        @(negedge clk); #1 chk("ws2 bank4", 64'(bank2[4]), 64'(32'h4444_0004));

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
